// File: rtl/dmem_pkg.sv
// Shared types and constants for the block-granular data memory and its cache-side bus.
package dmem_pkg;

    localparam int BLOCK_W = 128;
    localparam int ADDR_W  = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Cache <-> main memory block bus; the cache is the master, the memory is the slave.
interface dmem_if;
    import dmem_pkg::*;

    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;

    modport master (
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );

endinterface

// File: rtl/dmem_block_array.sv
// DEPTH x BLOCK_W block storage with a registered, enable-gated read port.
// The storage itself is never cleared; only the read register resets.
module dmem_block_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   windex_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    input  logic               re_i,
    input  logic [IDX_W-1:0]   rindex_i,
    output logic [BLOCK_W-1:0] rdata_o
);

    logic [BLOCK_W-1:0] mem_q [DEPTH];
    logic [BLOCK_W-1:0] rdata_q;

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[windex_i] <= wdata_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[rindex_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_block.sv
// Main-memory block responder: fixed-latency block reads/writes, stalls the cache via busywait.
// Optional simulation protocol checks are compiled in when DMEM_PROTOCOL_CHECK_EN is defined.
module data_memory_block
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5
) (
    input  logic   clock_i,
    input  logic   reset_i,
    dmem_if.slave  mem_if
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    dmem_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;

    logic               req;
    logic               commit;
    logic               busywait;
    logic               c_wr;
    logic [IDX_W-1:0]   c_idx;
    logic [BLOCK_W-1:0] c_wdata;
    logic [IDX_W-1:0]   idx_in;
    logic               unused_addr_hi;

    assign req            = mem_if.mem_read | mem_if.mem_write;
    assign idx_in         = mem_if.mem_address[IDX_W-1:0];
    assign unused_addr_hi = ^mem_if.mem_address[ADDR_W-1:IDX_W];

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        wr_q    <= wr_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wr_d    = mem_if.mem_write;
                    idx_d   = idx_in;
                    wdata_d = mem_if.mem_writedata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With LATENCY==1 the commit happens on the accept edge, so operands come straight off the bus.
    always_comb begin
        busywait = 1'b0;
        commit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busywait = req;
                commit   = req && (LATENCY == 1);
            end
            ST_BUSY: begin
                busywait = 1'b1;
                commit   = (cnt_q <= CNT_W'(1));
            end
            default: ;
        endcase
        if (!reset_i) begin
            busywait = 1'b0;
            commit   = 1'b0;
        end
    end

    assign c_wr    = (state_q == ST_IDLE) ? mem_if.mem_write     : wr_q;
    assign c_idx   = (state_q == ST_IDLE) ? idx_in               : idx_q;
    assign c_wdata = (state_q == ST_IDLE) ? mem_if.mem_writedata : wdata_q;

    dmem_block_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .we_i     (commit & c_wr),
        .windex_i (c_idx),
        .wdata_i  (c_wdata),
        .re_i     (commit & ~c_wr),
        .rindex_i (c_idx),
        .rdata_o  (mem_if.mem_readdata)
    );

    assign mem_if.mem_busywait = busywait;

`ifdef DMEM_PROTOCOL_CHECK_EN
    initial begin
        if (LATENCY < 1) $error("data_memory_block: LATENCY must be >= 1");
        if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) $error("data_memory_block: DEPTH must be a power of two");
    end

    always @(posedge clock_i) begin
        if (reset_i) begin
            if (state_q == ST_IDLE && mem_if.mem_read && mem_if.mem_write)
                $error("data_memory_block: mem_read and mem_write both high");
            if (state_q == ST_BUSY) begin
                if (!(wr_q ? mem_if.mem_write : mem_if.mem_read))
                    $error("data_memory_block: request dropped while busy");
                if (idx_in != idx_q)
                    $error("data_memory_block: address changed while busy");
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_block.sv
// Scoreboard bench for data_memory_block: directed scenarios followed by random block traffic.
module tb_data_memory_block;

    localparam int LAT   = 5;
    localparam int DEPTH = 256;

    typedef struct {
        bit           is_rd;
        logic [127:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus ();

    data_memory_block #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .mem_if  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    sb_t sb[$];

    logic [127:0] ref_mem [DEPTH];
    bit           ref_vld [DEPTH];
    int           written[$];
    logic [127:0] last_rd = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every busywait high-run ending while out of reset is one completed access.
    initial begin
        int  run;
        bit  prev;
        sb_t e;
        run  = 0;
        prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run  = 0;
                prev = 0;
            end else begin
                if (bus.mem_busywait) begin
                    run++;
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 128'(run), 128'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("latency", 128'(run), 128'(LAT));
                        chk(e.is_rd ? "rd_data" : "rd_hold", bus.mem_readdata, e.data);
                    end
                    run = 0;
                end
                prev = bus.mem_busywait;
            end
        end
    end

    task automatic idle(input int n);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one access and hold it until busywait is seen low again; returns one tick after that edge.
    task automatic access(input bit rd, input bit wr, input logic [27:0] addr,
                          input logic [127:0] data, input int chg_at, input int drop_at);
        int idx;
        int cyc;
        bit seen;
        idx = int'(addr[7:0]);
        if (wr) begin
            ref_mem[idx] = data;
            if (!ref_vld[idx]) written.push_back(idx);
            ref_vld[idx] = 1'b1;
            sb.push_back('{is_rd: 1'b0, data: last_rd});
        end else begin
            last_rd = ref_mem[idx];
            sb.push_back('{is_rd: 1'b1, data: last_rd});
        end
        bus.mem_read      = rd;
        bus.mem_write     = wr;
        bus.mem_address   = addr;
        bus.mem_writedata = data;
        cyc  = 0;
        seen = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_busywait) seen = 1;
            else if (seen) break;
            if (cyc == chg_at) begin
                bus.mem_address   = addr ^ 28'h2;
                bus.mem_writedata = ~data;
            end
            if (cyc == drop_at) begin
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
            if (cyc > LAT + 10) begin
                chk("access_timeout", 128'(cyc), 128'(LAT + 1));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        logic [127:0] b_old;
        int           idx;
        bit           do_wr;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_vld[i] = 1'b0;
        end
        bus.mem_read      = 1'b1;
        bus.mem_write     = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writedata = '0;

        // Reset held with a request pending: busywait must stay forced low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busywait", 128'(bus.mem_busywait), 128'(0));
        chk("rst_readdata", bus.mem_readdata, 128'h0);
        bus.mem_read = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_busywait", 128'(bus.mem_busywait), 128'(0));
        end
        @(posedge clk);
        #1;

        access(1'b0, 1'b1, 28'h0000003, 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF, -1, -1);
        idle(1);
        access(1'b1, 1'b0, 28'h0000003, '0, -1, -1);
        idle(2);

        // Write-back immediately followed by refill, zero gap.
        access(1'b0, 1'b1, 28'h0000005, 128'hAAAA0000_1111_2222_3333_4444_5555_6666, -1, -1);
        access(1'b1, 1'b0, 28'h0000005, '0, -1, -1);
        idle(1);

        // Mid-access address change and request drop are ignored.
        access(1'b1, 1'b0, 28'h0000005, '0, 3, -1);
        idle(1);
        access(1'b0, 1'b1, 28'h000000B, 128'h0D0D0D0D_12345678_9ABCDEF0_0F0F0F0F, -1, 3);
        idle(1);
        access(1'b1, 1'b0, 28'h000000B, '0, -1, -1);
        idle(1);

        // Reset during the busy phase abandons the write.
        b_old = 128'h00B0_0000_0000_0000_0000_0000_0000_00B0;
        access(1'b0, 1'b1, 28'h0000009, b_old, -1, -1);
        idle(1);
        bus.mem_write     = 1'b1;
        bus.mem_address   = 28'h0000009;
        bus.mem_writedata = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("busy_before_rst", 128'(bus.mem_busywait), 128'(1));
        rst_n = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        chk("rst_mid_busy", 128'(bus.mem_busywait), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("idle_after_rst", 128'(bus.mem_busywait), 128'(0));
        last_rd = '0;
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 28'h0000009, '0, -1, -1);
        idle(1);

        // Read and write together resolve as a write.
        access(1'b1, 1'b1, 28'h000000A, 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3, -1, -1);
        idle(1);
        access(1'b1, 1'b0, 28'hABCDE0A, '0, -1, -1);
        idle(1);

        for (int n = 0; n < 60; n++) begin
            do_wr = (written.size() == 0) || ($urandom_range(1, 0) == 1);
            if (do_wr) begin
                idx = int'($urandom_range(DEPTH - 1, 0));
                d   = {$urandom, $urandom, $urandom, $urandom};
                access(($urandom_range(7, 0) == 0), 1'b1,
                       {20'($urandom), 8'(idx)}, d,
                       ($urandom_range(3, 0) == 0) ? 3 : -1,
                       ($urandom_range(3, 0) == 0) ? 4 : -1);
            end else begin
                idx = written[$urandom_range(written.size() - 1, 0)];
                access(1'b1, 1'b0, {20'($urandom), 8'(idx)}, '0,
                       ($urandom_range(3, 0) == 0) ? 2 : -1,
                       ($urandom_range(3, 0) == 0) ? 3 : -1);
            end
            if ($urandom_range(2, 0) != 0) idle($urandom_range(2, 1));
        end

        idle(5);
        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
